// File: rtl/subleq_pkg.sv
// subleq_pkg: shared widths, halt target and sequencer state encoding for the SUBLEQ controller
package subleq_pkg;
  localparam int WORD_W = 8;
  localparam logic [WORD_W-1:0] HALT_ADDR = 8'hFF;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    F_A  = 3'd1,
    F_B  = 3'd2,
    F_C  = 3'd3,
    RD_A = 3'd4,
    RD_B = 3'd5,
    EXEC = 3'd6,
    HALT = 3'd7
  } state_t;
endpackage

// File: rtl/mux_2x1.sv
// mux_2x1: byte-wide 2:1 select, sel=1 picks a
module mux_2x1
  import subleq_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              sel,
  output logic [WORD_W-1:0] out_port
);
  assign out_port = sel ? a : b;
endmodule

// File: rtl/subleq_ctrl.sv
// subleq_ctrl: SUBLEQ fetch/execute sequencer driving a single-port memory and the next-PC mux
module subleq_ctrl
  import subleq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [WORD_W-1:0] pc,
  output logic              halted,
  output logic              instr_done
);
  state_t state;
  logic [WORD_W-1:0] a, b, c, op_a, diff, pc_next;
  logic leq;
  // mem[b] arrives in EXEC, so the write data and branch decision are combinational there
  always_comb begin
    diff = mem_rdata - op_a;
    leq  = diff[WORD_W-1] | (diff == '0);
  end
  assign mem_wdata = (state == EXEC) ? diff : '0;
  mux_2x1 u_mux (
    .a       (c),
    .b       (pc + WORD_W'(3)),
    .sel     (leq),
    .out_port(pc_next)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= '0;
      a          <= '0;
      b          <= '0;
      c          <= '0;
      op_a       <= '0;
      mem_addr   <= '0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      halted     <= 1'b0;
      instr_done <= 1'b0;
    end else begin
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      instr_done <= 1'b0;
      // strobes and address are set up one edge ahead of the state that owns them
      case (state)
        IDLE: if (run) begin
          state    <= F_A;
          mem_re   <= 1'b1;
          mem_addr <= pc;
        end
        F_A: begin
          state    <= F_B;
          mem_re   <= 1'b1;
          mem_addr <= pc + WORD_W'(1);
        end
        F_B: begin
          a        <= mem_rdata;
          state    <= F_C;
          mem_re   <= 1'b1;
          mem_addr <= pc + WORD_W'(2);
        end
        F_C: begin
          b        <= mem_rdata;
          state    <= RD_A;
          mem_re   <= 1'b1;
          mem_addr <= a;
        end
        RD_A: begin
          c        <= mem_rdata;
          state    <= RD_B;
          mem_re   <= 1'b1;
          mem_addr <= b;
        end
        RD_B: begin
          op_a       <= mem_rdata;
          state      <= EXEC;
          mem_we     <= 1'b1;
          instr_done <= 1'b1;
        end
        EXEC: begin
          pc <= pc_next;
          if (leq && c == HALT_ADDR) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (run) begin
            state    <= F_A;
            mem_re   <= 1'b1;
            mem_addr <= pc_next;
          end else begin
            state <= IDLE;
          end
        end
        HALT: state <= HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_subleq_ctrl.sv
// tb_subleq_ctrl: directed and random programs checked against an instruction-level SUBLEQ model
module tb_subleq_ctrl;
  logic       clk, rst, run;
  logic [7:0] mem_rdata, mem_addr, mem_wdata, pc;
  logic       mem_re, mem_we, halted, instr_done;

  subleq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .pc        (pc),
    .halted    (halted),
    .instr_done(instr_done)
  );

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] ref_pc;
  logic       ref_halt, drop_run;
  logic [7:0] rd_q [$];
  int cyc, last_mark, done_cnt, overlap, checks, errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) mem[mem_addr] = mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_re) rd_q.push_back(mem_addr);
    if (mem_re && mem_we) overlap++;
    if (instr_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic sync_ref();
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    ref_pc = 8'h00;
    ref_halt = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    drop_run = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd_q.delete();
    done_cnt = 0;
  endtask

  task automatic start();
    @(negedge clk);
    run = 1'b1;
    last_mark = cyc;
  endtask

  // One instruction of the model, then the DUT is checked against it
  task automatic do_instr();
    logic [7:0] p, ea, eb, ec, ed, epc;
    logic [7:0] exp_rd [5];
    logic eh, taken;
    int n;
    p = ref_pc;
    ea = ref_mem[p];
    eb = ref_mem[8'(p + 1)];
    ec = ref_mem[8'(p + 2)];
    ed = ref_mem[eb] - ref_mem[ea];
    taken = $signed(ed) <= 0;
    ref_mem[eb] = ed;
    epc = taken ? ec : 8'(p + 3);
    eh = taken && ec == 8'hFF;
    exp_rd = '{p, 8'(p + 1), 8'(p + 2), ea, eb};
    n = 0;
    while (!instr_done && n < 40) begin
      @(negedge clk);
      n++;
      if (drop_run && cyc - last_mark == 5) run = 1'b0;
    end
    check("done_wait", {31'd0, instr_done}, 32'd1);
    check("cycles", cyc - last_mark, 32'd6);
    last_mark = cyc;
    check("read_count", rd_q.size(), 32'd5);
    for (int i = 0; i < 5 && i < rd_q.size(); i++) check("read_addr", {24'd0, rd_q[i]}, {24'd0, exp_rd[i]});
    rd_q.delete();
    check("exec_we", {31'd0, mem_we}, 32'd1);
    check("exec_re", {31'd0, mem_re}, 32'd0);
    check("exec_addr", {24'd0, mem_addr}, {24'd0, eb});
    check("exec_wdata", {24'd0, mem_wdata}, {24'd0, ed});
    @(posedge clk);
    #1;
    check("pc", {24'd0, pc}, {24'd0, epc});
    check("mem_b", {24'd0, mem[eb]}, {24'd0, ed});
    check("halted", {31'd0, halted}, {31'd0, eh});
    check("done_pulse", {31'd0, instr_done}, 32'd0);
    ref_pc = epc;
    ref_halt = eh;
  endtask

  initial begin
    logic [7:0] b_addr, old;
    int n;
    checks = 0; errors = 0; cyc = 0; overlap = 0; done_cnt = 0;
    rst = 1'b0; run = 1'b0; drop_run = 1'b0;
    clear_mem();
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_pc", {24'd0, pc}, 32'd0);
    check("rst_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_re", {31'd0, mem_re}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_wdata", {24'd0, mem_wdata}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_done", {31'd0, instr_done}, 32'd0);
    do_reset();
    // no branch: 7-5=2, then reset mid-F_C of the next instruction
    mem[0] = 8'd3; mem[1] = 8'd4; mem[2] = 8'd9; mem[3] = 8'd5; mem[4] = 8'd7;
    sync_ref();
    start();
    do_instr();
    check("t1_mem4", {24'd0, mem[4]}, 32'd2);
    check("t1_pc", {24'd0, pc}, 32'd3);
    check("t1_done_cnt", done_cnt, 32'd1);
    n = 0;
    while (cyc - last_mark != 3 && n < 20) begin @(negedge clk); n++; end
    check("fc_reached", {31'd0, mem_re}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("fc_rst_pc", {24'd0, pc}, 32'd0);
    check("fc_rst_re", {31'd0, mem_re}, 32'd0);
    check("fc_rst_we", {31'd0, mem_we}, 32'd0);
    check("fc_rst_halted", {31'd0, halted}, 32'd0);
    do_reset();
    // branch on zero: restart fetches from 0
    clear_mem();
    mem[0] = 8'd3; mem[1] = 8'd4; mem[2] = 8'd9; mem[3] = 8'd7; mem[4] = 8'd7;
    sync_ref();
    start();
    do_instr();
    check("t2_mem4", {24'd0, mem[4]}, 32'd0);
    check("t2_pc", {24'd0, pc}, 32'd9);
    do_reset();
    // signed wrap both ways, then halt
    clear_mem();
    mem[0] = 8'd10; mem[1] = 8'd11; mem[2] = 8'h20;
    mem[3] = 8'd12; mem[4] = 8'd13; mem[5] = 8'h30;
    mem[8'h30] = 8'd12; mem[8'h31] = 8'd12; mem[8'h32] = 8'hFF;
    mem[10] = 8'h01; mem[11] = 8'h80; mem[12] = 8'h01; mem[13] = 8'h00;
    sync_ref();
    start();
    do_instr();
    check("wrap_pos", {24'd0, mem[11]}, 32'h7F);
    check("wrap_pos_pc", {24'd0, pc}, 32'd3);
    do_instr();
    check("wrap_neg", {24'd0, mem[13]}, 32'hFF);
    check("wrap_neg_pc", {24'd0, pc}, 32'h30);
    do_instr();
    check("halt_now", {31'd0, halted}, 32'd1);
    repeat (20) @(negedge clk);
    check("halt_no_reads", rd_q.size(), 32'd0);
    check("halt_pc", {24'd0, pc}, 32'hFF);
    check("halt_hold", {31'd0, halted}, 32'd1);
    check("halt_we", {31'd0, mem_we}, 32'd0);
    do_reset();
    // reset during EXEC must suppress the write
    clear_mem();
    mem[0] = 8'd5; mem[1] = 8'd6; mem[2] = 8'd0; mem[5] = 8'd1; mem[6] = 8'd9;
    start();
    n = 0;
    while (!instr_done && n < 20) begin @(negedge clk); n++; end
    check("ex_reached", {31'd0, mem_we}, 32'd1);
    b_addr = mem_addr;
    old = mem[b_addr];
    #1 rst = 1'b1;
    #1;
    check("ex_rst_we", {31'd0, mem_we}, 32'd0);
    check("ex_rst_done", {31'd0, instr_done}, 32'd0);
    @(posedge clk);
    #1;
    check("ex_no_write", {24'd0, mem[b_addr]}, {24'd0, old});
    check("ex_rst_pc", {24'd0, pc}, 32'd0);
    do_reset();
    // branch to FE, wrap fetch FE/FF/00, drop run in RD_B
    clear_mem();
    mem[0] = 8'h30; mem[1] = 8'h30; mem[2] = 8'hFE; mem[8'h30] = 8'd4;
    mem[8'hFE] = 8'h20; mem[8'hFF] = 8'h21; mem[8'h20] = 8'd1; mem[8'h21] = 8'd5;
    sync_ref();
    start();
    do_instr();
    check("to_fe", {24'd0, pc}, 32'hFE);
    drop_run = 1'b1;
    do_instr();
    drop_run = 1'b0;
    check("pc_wrap", {24'd0, pc}, 32'h01);
    repeat (5) @(negedge clk);
    check("idle_no_reads", rd_q.size(), 32'd0);
    check("idle_pc", {24'd0, pc}, 32'h01);
    check("idle_done_cnt", done_cnt, 32'd2);
    // random programs
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      sync_ref();
      start();
      for (int k = 0; k < 30 && !ref_halt; k++) do_instr();
      run = 1'b0;
      for (int i = 0; i < 256; i++) check("rand_mem", {24'd0, mem[i]}, {24'd0, ref_mem[i]});
    end
    check("re_we_exclusive", overlap, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
